// File: rtl/cpu_pkg.sv
// Shared CPU datapath definitions.
// - PC_WIDTH: default datapath width for the program counter and the system bus.
// - action_e: the single action the program counter takes in a cycle. The priority encoder
//   produces it, and the bench scoreboard uses the same encoding.
package cpu_pkg;

    localparam int unsigned PC_WIDTH = 16;

    typedef enum logic [2:0] {
        ACT_HOLD,
        ACT_LOAD,
        ACT_REL,
        ACT_CALL,
        ACT_RET,
        ACT_INC
    } action_e;

endpackage

// File: rtl/program_counter_stack_if.sv
// Control and status bundle for program_counter_stack.
// - master: the controller. It drives the command strobes and observes pc, sp and the flags.
// - slave:  the program counter itself.
// The shared data bus stays a plain inout on the top module so that it can resolve against
// the other drivers on the system bus.
interface program_counter_stack_if #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SP_W  = 4
);
    logic             pc_in;
    logic             pc_out;
    logic             rel_en;
    logic             inc;
    logic             call;
    logic             ret;
    logic [WIDTH-1:0] pc;
    logic [SP_W-1:0]  sp;
    logic             stack_overflow;
    logic             stack_underflow;

    modport master (
        output pc_in, pc_out, rel_en, inc, call, ret,
        input  pc, sp, stack_overflow, stack_underflow
    );

    modport slave (
        input  pc_in, pc_out, rel_en, inc, call, ret,
        output pc, sp, stack_overflow, stack_underflow
    );
endinterface

// File: rtl/ret_addr_stack.sv
// Return-address LIFO holding Depth entries of Width bits each.
// Ports:
//   clock, reset   : clock and synchronous active-high reset (clears the count only)
//   push_i         : write push_data_i on top; ignored when the stack is full
//   pop_i          : drop the top entry; ignored when the stack is empty
//   push_data_i    : entry to push
//   top_o          : current top entry (undefined when the stack is empty)
//   full_o, empty_o: occupancy status
//   count_o        : number of valid entries, 0..Depth
// The caller never asserts push_i and pop_i in the same cycle.
module ret_addr_stack #(
    parameter int unsigned Width = 16,
    parameter int unsigned Depth = 8,
    localparam int unsigned AddrW = $clog2(Depth)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [Width-1:0] push_data_i,
    output logic [Width-1:0] top_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [AddrW:0]   count_o
);
    logic [Width-1:0] mem_q [Depth];
    logic [AddrW:0]   cnt_q, cnt_d;
    logic [AddrW-1:0] wr_idx;
    logic [AddrW-1:0] top_idx;

    assign full_o  = (cnt_q == (AddrW+1)'(Depth));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;

    // Depth is a power of two, so the low bits index the slot and never overflow
    // while a push is permitted.
    assign wr_idx  = cnt_q[AddrW-1:0];
    assign top_idx = cnt_q[AddrW-1:0] - AddrW'(1);
    assign top_o   = mem_q[top_idx];

    always_comb begin
        cnt_d = cnt_q;
        if (push_i && !full_o) begin
            cnt_d = cnt_q + (AddrW+1)'(1);
        end else if (pop_i && !empty_o) begin
            cnt_d = cnt_q - (AddrW+1)'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Contents are don't-care after reset, so the storage has no reset.
    always_ff @(posedge clock) begin
        if (push_i && !full_o && !reset) begin
            mem_q[wr_idx] <= push_data_i;
        end
    end
endmodule

// File: rtl/program_counter_stack.sv
// Program counter with load, increment, relative branch and a hardware call/return stack.
// Ports:
//   clock, reset : system clock and synchronous active-high reset
//   ctrl_if      : command strobes in; pc, sp and the sticky stack flags out
//   data_bus     : shared tristate system bus. Loads and offsets are read from it, and the
//                  count is driven onto it while pc_out is high.
// Exactly one action runs per cycle: reset > pc_in > rel_en > call > ret > inc > hold.
module program_counter_stack
    import cpu_pkg::*;
#(
    parameter int unsigned WIDTH       = PC_WIDTH,
    parameter int unsigned STACK_DEPTH = 8,
    parameter int unsigned INC_STEP    = 1
) (
    input  logic                    clock,
    input  logic                    reset,
    program_counter_stack_if.slave  ctrl_if,
    inout  wire [WIDTH-1:0]         data_bus
);
    localparam int unsigned    SpW     = $clog2(STACK_DEPTH) + 1;
    localparam logic [WIDTH-1:0] IncStep = WIDTH'(INC_STEP);

    action_e          act;
    logic [WIDTH-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             push, pop;
    logic [WIDTH-1:0] ret_addr;
    logic [WIDTH-1:0] stack_top;
    logic             stack_full, stack_empty;
    logic [SpW-1:0]   stack_count;

    // The driver follows pc_out even during reset.
    assign data_bus = ctrl_if.pc_out ? count_q : 'z;

    assign ret_addr = count_q + IncStep;

    always_comb begin
        act = ACT_HOLD;
        if (ctrl_if.pc_in) begin
            act = ACT_LOAD;
        end else if (ctrl_if.rel_en) begin
            act = ACT_REL;
        end else if (ctrl_if.call) begin
            act = ACT_CALL;
        end else if (ctrl_if.ret) begin
            act = ACT_RET;
        end else if (ctrl_if.inc) begin
            act = ACT_INC;
        end
    end

    always_comb begin
        count_d = count_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        push    = 1'b0;
        pop     = 1'b0;
        unique case (act)
            ACT_LOAD: count_d = data_bus;
            // A two's-complement add handles negative offsets.
            ACT_REL:  count_d = count_q + data_bus;
            ACT_CALL: begin
                if (stack_full) begin
                    ovf_d = 1'b1;
                end else begin
                    push    = 1'b1;
                    count_d = data_bus;
                end
            end
            ACT_RET: begin
                if (stack_empty) begin
                    unf_d = 1'b1;
                end else begin
                    pop     = 1'b1;
                    count_d = stack_top;
                end
            end
            ACT_INC:  count_d = count_q + IncStep;
            default:  count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    ret_addr_stack #(
        .Width (WIDTH),
        .Depth (STACK_DEPTH)
    ) u_ret_addr_stack (
        .clock       (clock),
        .reset       (reset),
        .push_i      (push),
        .pop_i       (pop),
        .push_data_i (ret_addr),
        .top_o       (stack_top),
        .full_o      (stack_full),
        .empty_o     (stack_empty),
        .count_o     (stack_count)
    );

    assign ctrl_if.pc              = count_q;
    assign ctrl_if.sp              = stack_count;
    assign ctrl_if.stack_overflow  = ovf_q;
    assign ctrl_if.stack_underflow = unf_q;
endmodule

// File: tb/tb_program_counter_stack.sv
module tb_program_counter_stack;
    localparam int unsigned W = 16;

    logic         clock;
    logic         reset;
    logic         drv_en;
    logic [W-1:0] drv_val;
    wire  [W-1:0] data_bus;

    int n_checks;
    int n_fail;

    program_counter_stack_if #(.WIDTH(16), .SP_W(4)) pcs_if ();

    program_counter_stack #(
        .WIDTH       (16),
        .STACK_DEPTH (8),
        .INC_STEP    (1)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .ctrl_if  (pcs_if),
        .data_bus (data_bus)
    );

    assign data_bus = drv_en ? drv_val : 'z;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Controller misuse, not a design error: pc_out together with a bus read.
    always @(posedge clock) begin
        if (pcs_if.pc_out && (pcs_if.pc_in || pcs_if.rel_en || pcs_if.call)) begin
            $display("illegal command: pc_out with a bus read at %0t", $time);
        end
    end

    task automatic idle();
        pcs_if.pc_in  = 1'b0;
        pcs_if.pc_out = 1'b0;
        pcs_if.rel_en = 1'b0;
        pcs_if.inc    = 1'b0;
        pcs_if.call   = 1'b0;
        pcs_if.ret    = 1'b0;
        drv_en        = 1'b0;
        drv_val       = '0;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic load(input logic [W-1:0] v);
        idle();
        drv_en       = 1'b1;
        drv_val      = v;
        pcs_if.pc_in = 1'b1;
        step();
        idle();
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (pcs_if.pc !== 16'h0000 || pcs_if.sp !== 4'd0 || pcs_if.stack_overflow !== 1'b0
            || pcs_if.stack_underflow !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: pc=%h sp=%0d ovf=%b unf=%b, want 0000/0/0/0",
                     pcs_if.pc, pcs_if.sp, pcs_if.stack_overflow, pcs_if.stack_underflow);
        end
        pcs_if.inc = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            step();
            n_checks++;
            if (pcs_if.pc !== W'(i)) begin
                n_fail++;
                $display("FAIL inc_seq[%0d]: pc=%h want %h", i, pcs_if.pc, W'(i));
            end
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_checks++;
        if (pcs_if.pc !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_over_inc: pc=%h want 0000", pcs_if.pc);
        end
        idle();
    endtask

    task automatic test_load_bus();
        load(16'h1234);
        n_checks++;
        if (pcs_if.pc !== 16'h1234) begin
            n_fail++;
            $display("FAIL load: pc=%h want 1234", pcs_if.pc);
        end
        pcs_if.pc_out = 1'b1;
        #1;
        n_checks++;
        if (data_bus !== 16'h1234) begin
            n_fail++;
            $display("FAIL bus_drive: data_bus=%h want 1234", data_bus);
        end
        step();
        n_checks++;
        if (pcs_if.pc !== 16'h1234) begin
            n_fail++;
            $display("FAIL pc_out_hold: pc=%h want 1234", pcs_if.pc);
        end
        // With pc_out low the bench owns the bus; any DUT drive would corrupt the value.
        pcs_if.pc_out = 1'b0;
        drv_en        = 1'b1;
        drv_val       = 16'h00C3;
        #1;
        n_checks++;
        if (data_bus !== 16'h00C3) begin
            n_fail++;
            $display("FAIL bus_release: data_bus=%h want 00c3", data_bus);
        end
        idle();
    endtask

    task automatic test_rel_inc();
        load(16'h0100);
        drv_en        = 1'b1;
        drv_val       = 16'hFFFC;
        pcs_if.rel_en = 1'b1;
        step();
        idle();
        n_checks++;
        if (pcs_if.pc !== 16'h00FC) begin
            n_fail++;
            $display("FAIL rel_neg: pc=%h want 00fc", pcs_if.pc);
        end
        load(16'hFFFF);
        pcs_if.inc = 1'b1;
        step();
        idle();
        n_checks++;
        if (pcs_if.pc !== 16'h0000 || pcs_if.stack_overflow !== 1'b0
            || pcs_if.stack_underflow !== 1'b0) begin
            n_fail++;
            $display("FAIL inc_wrap: pc=%h ovf=%b unf=%b want 0000/0/0",
                     pcs_if.pc, pcs_if.stack_overflow, pcs_if.stack_underflow);
        end
    endtask

    task automatic test_call_ret();
        load(16'h0010);
        drv_en      = 1'b1;
        drv_val     = 16'h0200;
        pcs_if.call = 1'b1;
        step();
        idle();
        n_checks++;
        if (pcs_if.pc !== 16'h0200 || pcs_if.sp !== 4'd1) begin
            n_fail++;
            $display("FAIL call: pc=%h sp=%0d want 0200/1", pcs_if.pc, pcs_if.sp);
        end
        pcs_if.ret = 1'b1;
        step();
        idle();
        n_checks++;
        if (pcs_if.pc !== 16'h0011 || pcs_if.sp !== 4'd0) begin
            n_fail++;
            $display("FAIL ret: pc=%h sp=%0d want 0011/0", pcs_if.pc, pcs_if.sp);
        end
    endtask

    // Calls start from pc=0; call k jumps to 0x1000+k*0x100, so the return address
    // pushed by call k is 1 for k=0 and 0x1000+(k-1)*0x100+1 otherwise.
    function automatic logic [W-1:0] ret_of(input int k);
        return (k == 0) ? 16'h0001 : W'(32'h1000 + (k - 1) * 32'h100 + 1);
    endfunction

    task automatic test_stack_limits();
        do_reset();
        for (int k = 0; k < 8; k++) begin
            drv_en      = 1'b1;
            drv_val     = W'(32'h1000 + k * 32'h100);
            pcs_if.call = 1'b1;
            step();
            idle();
            n_checks++;
            if (pcs_if.pc !== W'(32'h1000 + k * 32'h100) || pcs_if.sp !== 4'(k + 1)) begin
                n_fail++;
                $display("FAIL nested_call[%0d]: pc=%h sp=%0d want %h/%0d", k, pcs_if.pc,
                         pcs_if.sp, W'(32'h1000 + k * 32'h100), k + 1);
            end
        end
        drv_en      = 1'b1;
        drv_val     = 16'hBEEF;
        pcs_if.call = 1'b1;
        step();
        idle();
        n_checks++;
        if (pcs_if.pc !== 16'h1700 || pcs_if.sp !== 4'd8 || pcs_if.stack_overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow: pc=%h sp=%0d ovf=%b want 1700/8/1", pcs_if.pc, pcs_if.sp,
                     pcs_if.stack_overflow);
        end
        for (int k = 7; k >= 0; k--) begin
            pcs_if.ret = 1'b1;
            step();
            idle();
            n_checks++;
            if (pcs_if.pc !== ret_of(k) || pcs_if.sp !== 4'(k)) begin
                n_fail++;
                $display("FAIL lifo_ret[%0d]: pc=%h sp=%0d want %h/%0d", k, pcs_if.pc,
                         pcs_if.sp, ret_of(k), k);
            end
        end
        pcs_if.ret = 1'b1;
        step();
        idle();
        n_checks++;
        if (pcs_if.pc !== 16'h0001 || pcs_if.sp !== 4'd0 || pcs_if.stack_underflow !== 1'b1
            || pcs_if.stack_overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL underflow: pc=%h sp=%0d unf=%b ovf=%b want 0001/0/1/1", pcs_if.pc,
                     pcs_if.sp, pcs_if.stack_underflow, pcs_if.stack_overflow);
        end
    endtask

    task automatic test_priority();
        do_reset();
        drv_en        = 1'b1;
        drv_val       = 16'h0050;
        pcs_if.pc_in  = 1'b1;
        pcs_if.rel_en = 1'b1;
        pcs_if.inc    = 1'b1;
        step();
        idle();
        n_checks++;
        if (pcs_if.pc !== 16'h0050) begin
            n_fail++;
            $display("FAIL prio_load: pc=%h want 0050", pcs_if.pc);
        end
        pcs_if.ret = 1'b1;
        pcs_if.inc = 1'b1;
        step();
        idle();
        n_checks++;
        if (pcs_if.pc !== 16'h0050 || pcs_if.sp !== 4'd0 || pcs_if.stack_underflow !== 1'b1
            || pcs_if.stack_overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL prio_ret_inc: pc=%h sp=%0d unf=%b ovf=%b want 0050/0/1/0",
                     pcs_if.pc, pcs_if.sp, pcs_if.stack_underflow, pcs_if.stack_overflow);
        end
        // Sticky flag survives ordinary activity.
        pcs_if.inc = 1'b1;
        step();
        idle();
        n_checks++;
        if (pcs_if.pc !== 16'h0051 || pcs_if.stack_underflow !== 1'b1) begin
            n_fail++;
            $display("FAIL sticky_unf: pc=%h unf=%b want 0051/1", pcs_if.pc,
                     pcs_if.stack_underflow);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        idle();
        step();
        test_reset();
        test_load_bus();
        test_rel_inc();
        test_call_ret();
        test_stack_limits();
        test_priority();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/program_counter_stack.md
Name: program_counter_stack

Overview:
- Parametrised program counter for the CPU datapath with load, increment, relative branch and a hardware return-address stack for call/return.
- Shares the tristate system data bus with other datapath registers. Loads from the bus on pc_in and drives its count onto the bus on pc_out.
- Instruction-fetch address comes from the pc output.

Parameters:
WIDTH, 16, bit width of counter, bus and stack entries
STACK_DEPTH, 8, number of return-address entries (power of 2, >=2)
INC_STEP, 1, amount added on inc and used to form return address

Ports:
clock  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high; clears all state
pc_in  input  1  load count from data_bus (absolute jump)
pc_out  input  1  drive count onto data_bus
rel_en  input  1  add data_bus (two's-complement signed) to count
inc  input  1  add INC_STEP to count
call  input  1  push count+INC_STEP, then jump to data_bus
ret  input  1  pop top of stack into count
data_bus  inout  WIDTH  shared system bus
pc  output  WIDTH  current count (fetch address)
sp  output  clog2(STACK_DEPTH)+1  number of valid stack entries
stack_overflow  output  1  sticky: call attempted while stack full
stack_underflow  output  1  sticky: ret attempted while stack empty

Behaviour:
- Reset (sync, active-high), highest priority:
  - count=0, sp=0, both sticky flags=0.
  - Stack contents are don't-care.
  - Bus drive still follows pc_out during reset.
- Command priority per cycle, exactly one action executes: reset > pc_in > rel_en > call > ret > inc > hold.
- pc_in: count <= data_bus. Stack untouched.
- rel_en: count <= count + data_bus, modulo 2^WIDTH. Signed offset, so 16'hFFFF means -1.
- call:
  - If sp < STACK_DEPTH: stack[sp] <= count+INC_STEP, sp <= sp+1, count <= data_bus.
  - If full: no push, no jump, count holds, stack_overflow <= 1.
- ret:
  - If sp > 0: count <= stack[sp-1], sp <= sp-1.
  - If empty: count holds, stack_underflow <= 1.
- inc: count <= count + INC_STEP, wraps modulo 2^WIDTH (16'hFFFF+1 -> 0). No flag.
- Latency: every update is visible on pc and on the bus one clock after the command edge.
- Bus drive:
  - data_bus = count when pc_out=1, else high-Z. Purely combinational from pc_out and count.
  - pc_out with pc_in, rel_en or call in the same cycle is a bus conflict. The block then sees its own count on the bus:
    - pc_in: count unchanged.
    - rel_en: count doubles.
    - call: jumps to own count and pushes count+INC_STEP.
  - The controller must not issue these combinations. The bench flags them as illegal, not as RTL errors.
- The stack never wraps: sp saturates at 0 and STACK_DEPTH.
- Sticky flags clear only on reset.
- pc and sp are registered outputs with no combinational path from inputs.

Decomposition:
- Shared package cpu_pkg holds:
  - WIDTH default constant.
  - Action encoding enum: ACT_HOLD, ACT_LOAD, ACT_REL, ACT_CALL, ACT_RET, ACT_INC, used by the priority encoder and by the bench scoreboard.
- One natural sub-module, ret_addr_stack:
  - Synchronous LIFO of STACK_DEPTH x WIDTH with push, pop, full, empty and count.
  - Push and pop are never issued in the same cycle.
- The top level keeps the count register, the priority encoder, the adder and the tristate driver.

Test Plan:
- Reset then 3 cycles inc -> pc=0,1,2,3. Reset asserted while inc=1 -> pc=0 next cycle.
- pc_in with bus=16'h1234, then pc_out with pc_in=0 -> pc=16'h1234 and data_bus reads 16'h1234. pc_out=0 -> bus is Z.
- pc=16'h0100, rel_en with bus=16'hFFFC -> pc=16'h00FC. pc=16'hFFFF, inc -> pc=16'h0000, no flags.
- pc=16'h0010, call bus=16'h0200 -> pc=16'h0200, sp=1. ret -> pc=16'h0011, sp=0.
- 8 nested calls fill the stack (sp=8). A 9th call -> pc unchanged, stack_overflow=1. 8 rets return addresses in LIFO order. A 9th ret -> stack_underflow=1, pc holds.
- pc_in, rel_en and inc asserted together with bus=16'h0050 -> only the load happens, pc=16'h0050. ret and inc together on empty stack -> underflow set, pc holds (no increment).
